sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 Parameter VGA_MAX_WAIT, default 16, cycles a pending VGA request may lose arbitration before promotion to top priority.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 instReq  input  1  instruction-fetch read request, held until instAck.
REQ-006 instAddr  input  ADDR_W  fetch address.
REQ-007 instAck  output  1  one-cycle pulse; instData valid in the same cycle.
REQ-008 instData  output  16  fetched word.
REQ-009 dataReq  input  1  CPU data request, held until dataAck.
REQ-010 dataWe  input  1  1 = write, 0 = read.
REQ-011 dataAddr  input  ADDR_W  data address.
REQ-012 dataWdata  input  16  write data.
REQ-013 dataAck  output  1  one-cycle completion pulse.
REQ-014 dataRdata  output  16  read word, valid with dataAck.
REQ-015 vgaReq / vgaAddr / vgaAck / vgaData  input 1 / input ADDR_W / output 1 / output 16  framebuffer read port, same handshake as the fetch port.
REQ-016 memAddrBus  output  ADDR_W  SRAM address.
REQ-017 memDataBus  inout  16  SRAM data; driven only in write states, otherwise high-Z.
REQ-018 memEnable, memRead, memWrite  output  1 each  SRAM CE/OE/WE, active-low.
REQ-019 busy  output  1  high in every non-IDLE state.

Function
REQ-020 FSM states SHALL be IDLE, RD1, RD2, WR1, WR2, WR3.
REQ-021 In IDLE, when any eligible request is present, the arbiter SHALL latch owner, address, write flag and write data, then move to RD1 (read) or WR1 (write).
REQ-022 Priority SHALL be data > fetch > VGA, except that a promoted VGA request beats all others.
REQ-023 VGA wait counter: increments each cycle vgaReq=1 and VGA not granted; saturates at VGA_MAX_WAIT; clears when VGA is granted or vgaReq=0; VGA is promoted while counter = VGA_MAX_WAIT.
REQ-024 A port whose ack is high in the current cycle SHALL be ineligible in that cycle; a requester SHALL deassert req in its ack cycle.
REQ-025 Read: RD1 and RD2 drive memEnable=0, memRead=0, memWrite=1, and the latched address; at the RD2->IDLE edge, memDataBus is captured into the owner's data output and the owner's ack is set.
REQ-026 Read latency: request sampled in IDLE at cycle 0 -> ack high in cycle 3.
REQ-027 Write: WR1 drives address and data with memEnable=0, memWrite=1; WR2 additionally sets memWrite=0; WR3 sets memWrite=1 with address and data still driven; at the WR3->IDLE edge, dataAck is set.
REQ-028 Write latency: ack high in cycle 4; memRead SHALL stay 1 throughout a write.
REQ-029 Write requests SHALL only come from the data port; fetch and VGA are always reads.
REQ-030 Ack SHALL be a one-cycle pulse to exactly one port; output data registers SHALL hold their value until that port's next ack.
REQ-031 In IDLE, memEnable, memRead and memWrite SHALL be 1, memDataBus SHALL be high-Z, and memAddrBus SHALL hold its last value.
REQ-032 Back-to-back transfers: a new grant is allowed in the ack cycle, subject to REQ-024.
REQ-033 Request changes during a transfer SHALL not affect it, because address and data are latched at grant.

Reset
REQ-034 When rst=1 at an edge, the FSM SHALL go to IDLE from any state, abandoning an in-flight transfer with no ack.
REQ-035 Reset values SHALL be: all acks 0, instData/dataRdata/vgaData 0x0000, memAddrBus 0, memEnable/memRead/memWrite 1, bus high-Z, busy 0, VGA wait counter 0.

Verification
REQ-036 Single fetch: instReq with instAddr 0x00010 and SRAM model holding 0x1234 -> instAck in cycle 3 with instData 0x1234; memRead low only in RD1/RD2.
REQ-037 Write then read: data write 0xBEEF to 0x00020, then data read of 0x00020 -> memWrite low exactly one cycle (WR2); dataAck in cycle 4; read returns 0xBEEF.
REQ-038 Simultaneous data, fetch and VGA requests with a fresh counter -> grant order data, fetch, VGA; each ack pulses exactly once.
REQ-039 VGA starvation: dataReq and instReq continuously reasserted, vgaReq held -> VGA granted no later than the first IDLE decision after its counter reaches 16.
REQ-040 Reset in WR2 -> next cycle IDLE, memWrite=1, bus high-Z, no dataAck; a subsequent read succeeds normally.
REQ-041 Held request after ack: instReq kept high one cycle past instAck -> no second grant in the ack cycle.

Source files
------------

// File: rtl/sram_arbiter.sv
// Three-port arbiter for an asynchronous 16-bit SRAM.
// Data, instruction-fetch and VGA requesters share one SRAM. Data has
// priority over fetch, and fetch over VGA. A VGA request that has waited
// VGA_MAX_WAIT cycles is promoted above everything else.
// Reads take RD1/RD2 and writes take WR1/WR2/WR3. All SRAM strobes are
// registered and active-low.
module sram_arbiter #(
   parameter int ADDR_W       = 18,
   parameter int VGA_MAX_WAIT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instReq,
   input  logic [ADDR_W-1:0] instAddr,
   output logic              instAck,
   output logic [15:0]       instData,
   input  logic              dataReq,
   input  logic              dataWe,
   input  logic [ADDR_W-1:0] dataAddr,
   input  logic [15:0]       dataWdata,
   output logic              dataAck,
   output logic [15:0]       dataRdata,
   input  logic              vgaReq,
   input  logic [ADDR_W-1:0] vgaAddr,
   output logic              vgaAck,
   output logic [15:0]       vgaData,
   output logic [ADDR_W-1:0] memAddrBus,
   inout  wire  [15:0]       memDataBus,
   output logic              memEnable,
   output logic              memRead,
   output logic              memWrite,
   output logic              busy
);

   localparam int CNT_W = $clog2(VGA_MAX_WAIT + 1);

   typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, WR3} state_t;
   typedef enum logic [1:0] {OWN_DATA, OWN_INST, OWN_VGA} owner_t;

   state_t            state_q;
   owner_t            owner_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic [15:0]       wdata_q;
   logic              drive_q;
   logic              memEnable_q, memRead_q, memWrite_q;
   logic              instAck_q, dataAck_q, vgaAck_q;
   logic [15:0]       instData_q, dataRdata_q, vgaData_q;
   logic [CNT_W-1:0]  vga_wait_q, vga_wait_d;

   logic              grant_d;
   owner_t            grant_owner_d;
   logic [ADDR_W-1:0] grant_addr_d;
   logic              grant_we_d;

   // A port is never re-granted in the cycle its own ack is showing.
   logic elig_data, elig_inst, elig_vga, vga_promoted, grant_vga;
   assign elig_data    = dataReq & ~dataAck_q;
   assign elig_inst    = instReq & ~instAck_q;
   assign elig_vga     = vgaReq  & ~vgaAck_q;
   assign vga_promoted = (vga_wait_q == CNT_W'(VGA_MAX_WAIT));
   assign grant_vga    = grant_d && (grant_owner_d == OWN_VGA);

   // Priority decision, only meaningful while IDLE.
   always_comb begin
      grant_d       = 1'b0;
      grant_owner_d = OWN_DATA;
      grant_addr_d  = dataAddr;
      grant_we_d    = 1'b0;
      if (state_q == IDLE) begin
         if (elig_vga && vga_promoted) begin
            grant_d       = 1'b1;
            grant_owner_d = OWN_VGA;
            grant_addr_d  = vgaAddr;
         end else if (elig_data) begin
            grant_d       = 1'b1;
            grant_owner_d = OWN_DATA;
            grant_addr_d  = dataAddr;
            grant_we_d    = dataWe;
         end else if (elig_inst) begin
            grant_d       = 1'b1;
            grant_owner_d = OWN_INST;
            grant_addr_d  = instAddr;
         end else if (elig_vga) begin
            grant_d       = 1'b1;
            grant_owner_d = OWN_VGA;
            grant_addr_d  = vgaAddr;
         end
      end
   end

   // VGA starvation counter: counts lost cycles, saturates, clears on grant or drop.
   always_comb begin
      vga_wait_d = vga_wait_q;
      if (!vgaReq || grant_vga) begin
         vga_wait_d = '0;
      end else if (!vga_promoted) begin
         vga_wait_d = vga_wait_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) vga_wait_q <= '0;
      else     vga_wait_q <= vga_wait_d;
   end

   // Transfer FSM with registered SRAM strobes, acks and read-data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_DATA;
         memAddr_q   <= '0;
         drive_q     <= 1'b0;
         memEnable_q <= 1'b1;
         memRead_q   <= 1'b1;
         memWrite_q  <= 1'b1;
         instAck_q   <= 1'b0;
         dataAck_q   <= 1'b0;
         vgaAck_q    <= 1'b0;
         instData_q  <= 16'h0000;
         dataRdata_q <= 16'h0000;
         vgaData_q   <= 16'h0000;
      end else begin
         instAck_q <= 1'b0;
         dataAck_q <= 1'b0;
         vgaAck_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_d) begin
                  owner_q     <= grant_owner_d;
                  memAddr_q   <= grant_addr_d;
                  memEnable_q <= 1'b0;
                  if (grant_we_d) begin
                     wdata_q <= dataWdata;
                     drive_q <= 1'b1;
                     state_q <= WR1;
                  end else begin
                     memRead_q <= 1'b0;
                     state_q   <= RD1;
                  end
               end
            end
            RD1: state_q <= RD2;
            RD2: begin
               state_q     <= IDLE;
               memEnable_q <= 1'b1;
               memRead_q   <= 1'b1;
               case (owner_q)
                  OWN_DATA: begin dataRdata_q <= memDataBus; dataAck_q <= 1'b1; end
                  OWN_INST: begin instData_q  <= memDataBus; instAck_q <= 1'b1; end
                  OWN_VGA:  begin vgaData_q   <= memDataBus; vgaAck_q  <= 1'b1; end
                  default:  ;
               endcase
            end
            WR1: begin
               memWrite_q <= 1'b0;
               state_q    <= WR2;
            end
            WR2: begin
               memWrite_q <= 1'b1;
               state_q    <= WR3;
            end
            WR3: begin
               state_q     <= IDLE;
               memEnable_q <= 1'b1;
               drive_q     <= 1'b0;
               dataAck_q   <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign memDataBus = drive_q ? wdata_q : 16'hzzzz;
   assign memAddrBus = memAddr_q;
   assign memEnable  = memEnable_q;
   assign memRead    = memRead_q;
   assign memWrite   = memWrite_q;
   assign instAck    = instAck_q;
   assign instData   = instData_q;
   assign dataAck    = dataAck_q;
   assign dataRdata  = dataRdata_q;
   assign vgaAck     = vgaAck_q;
   assign vgaData    = vgaData_q;
   assign busy       = (state_q != IDLE);

endmodule
